spi_register_responder: RTL

SPI mode-0 slave that exposes a 32 x 8 register file to an external SPI master, such as the SoC's spi0 port that drives the USB host controller. It uses a MAX3421E-style framing: a command byte, then data bytes. The block sits on the FPGA fabric side so that the SoC's SPI master can be looped back onto programmable logic for bring-up and for modelling the USB controller. A local port gives game logic direct read/write access to the same registers.

---
 rtl/spi_register_responder_if.sv | 22 ++
 rtl/spi_register_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_register_responder_if.sv
// SPI bus bundle for spi_register_responder.
// The master modport drives clock, data and select; the slave returns MISO.
interface spi_register_responder_if;
    logic spi_SCLK;
    logic spi_MOSI;
    logic spi_SS_n;
    logic spi_MISO;

    modport master (
        output spi_SCLK,
        output spi_MOSI,
        output spi_SS_n,
        input  spi_MISO
    );

    modport slave (
        input  spi_SCLK,
        input  spi_MOSI,
        input  spi_SS_n,
        output spi_MISO
    );
endinterface

// File: rtl/spi_register_responder.sv
// SPI mode-0 slave exposing a 2^ADDR_W x 8 register file (MAX3421E-style
// framing: command byte [7:3]=addr, [1]=write, then auto-incrementing data
// bytes). A local port gives direct access to the same registers.
// Optional feature macro: SPI_RESP_IRQ_EN (register 25 becomes a
// write-1-to-clear / local-set interrupt register masked by register 26).
module spi_register_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 5
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    spi_register_responder_if.slave spi,
    input  logic [7:0]        status,
    input  logic [ADDR_W-1:0] loc_addr,
    output logic [7:0]        loc_rdata,
    input  logic              loc_we,
    input  logic [7:0]        loc_wdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              irq
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] HIRQ_ADDR = ADDR_W'(5'd25);
    localparam logic [ADDR_W-1:0] HIEN_ADDR = ADDR_W'(5'd26);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic                   sclk_prev_r;
    logic                   ss_prev_r;
    logic                   ss_seen_high_r;
    logic                   busy_r;

    state_t                 state_r;
    logic [2:0]             bit_cnt_r;
    logic [6:0]             shift_in_r;
    logic [7:0]             shift_out_r;
    logic [ADDR_W-1:0]      addr_r;
    logic                   dir_r;
    logic                   miso_r;
    logic                   wr_strobe_r;
    logic [ADDR_W-1:0]      wr_addr_r;
    logic [7:0]             wr_data_r;

    logic [7:0]             regs_r [DEPTH];

    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s;
    logic [7:0]             byte_in_s;
    logic                   commit_s;
    logic [ADDR_W-1:0]      cmd_addr_s;
    logic [ADDR_W-1:0]      next_addr_s;
    logic [7:0]             preload_s;
    logic [7:0]             spi_wval_s;
    logic [7:0]             loc_wval_s;

    // Synchronize the SPI pins and keep last-cycle copies for edge detection.
    // The SS_n chain resets low so a select already held low at reset release
    // never looks like a falling edge; a fresh high-then-low is required.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync_r    <= '0;
            mosi_sync_r    <= '0;
            ss_sync_r      <= '0;
            sclk_prev_r    <= 1'b0;
            ss_prev_r      <= 1'b0;
            ss_seen_high_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            sclk_sync_r    <= {sclk_sync_r[SYNC_STAGES-2:0], spi.spi_SCLK};
            mosi_sync_r    <= {mosi_sync_r[SYNC_STAGES-2:0], spi.spi_MOSI};
            ss_sync_r      <= {ss_sync_r[SYNC_STAGES-2:0], spi.spi_SS_n};
            sclk_prev_r    <= sclk_s;
            ss_prev_r      <= ss_s;
            ss_seen_high_r <= ss_seen_high_r | ss_s;
            busy_r         <= ss_seen_high_r & ~ss_s;
        end
    end

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign ss_s        = ss_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_s & sclk_prev_r;
    assign ss_fall_s   = ss_prev_r & ~ss_s;
    assign ss_rise_s   = ss_s & ~ss_prev_r;
    assign byte_in_s   = {shift_in_r, mosi_s};
    assign cmd_addr_s  = ADDR_W'(byte_in_s[7:3]);
    assign next_addr_s = addr_r + ADDR_W'(1'b1);
    assign commit_s    = (state_r == ST_DATA) && dir_r && sclk_rise_s &&
                         (bit_cnt_r == 3'd7) && !ss_rise_s;

    // Next byte to shift out: register contents for reads, zero for writes.
    always_comb begin
        preload_s = 8'h00;
        case (state_r)
            ST_CMD: begin
                if (byte_in_s[1]) preload_s = 8'h00;
                else              preload_s = regs_r[cmd_addr_s];
            end
            ST_DATA: begin
                if (dir_r) preload_s = 8'h00;
                else       preload_s = regs_r[next_addr_s];
            end
            default: preload_s = 8'h00;
        endcase
    end

    // Values stored by SPI and local writes (register 25 has special merge rules when IRQ is enabled).
    always_comb begin
        spi_wval_s = byte_in_s;
        loc_wval_s = loc_wdata;
`ifdef SPI_RESP_IRQ_EN
        if (addr_r == HIRQ_ADDR) spi_wval_s = regs_r[HIRQ_ADDR] & ~byte_in_s;
        else                     spi_wval_s = byte_in_s;
        if (loc_addr == HIRQ_ADDR) loc_wval_s = regs_r[HIRQ_ADDR] | loc_wdata;
        else                       loc_wval_s = loc_wdata;
`else
        spi_wval_s = byte_in_s;
        loc_wval_s = loc_wdata;
`endif
    end

    // Transfer FSM: command/data framing, bit counting, MISO shifting, write strobe.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_in_r  <= 7'd0;
            shift_out_r <= 8'h00;
            addr_r      <= '0;
            dir_r       <= 1'b0;
            miso_r      <= 1'b0;
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 8'h00;
        end else begin
            wr_strobe_r <= 1'b0;
            if (ss_rise_s) begin
                // Deselect aborts anything in flight; a partial byte is dropped.
                state_r   <= ST_IDLE;
                bit_cnt_r <= 3'd0;
                miso_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (ss_fall_s) begin
                            state_r     <= ST_CMD;
                            bit_cnt_r   <= 3'd0;
                            shift_out_r <= status;
                            miso_r      <= status[7];
                        end
                    end
                    ST_CMD, ST_DATA: begin
                        if (sclk_rise_s) begin
                            shift_in_r <= byte_in_s[6:0];
                            bit_cnt_r  <= bit_cnt_r + 3'd1;
                            if (bit_cnt_r == 3'd7) begin
                                shift_out_r <= preload_s;
                                if (state_r == ST_CMD) begin
                                    addr_r  <= cmd_addr_s;
                                    dir_r   <= byte_in_s[1];
                                    state_r <= ST_DATA;
                                end else begin
                                    addr_r <= next_addr_s;
                                    if (dir_r) begin
                                        wr_strobe_r <= 1'b1;
                                        wr_addr_r   <= addr_r;
                                        wr_data_r   <= byte_in_s;
                                    end
                                end
                            end
                        end else if (sclk_fall_s) begin
                            // After a byte boundary the freshly preloaded MSB is
                            // presented as-is; otherwise advance one bit.
                            if (bit_cnt_r == 3'd0) begin
                                miso_r <= shift_out_r[7];
                            end else begin
                                miso_r      <= shift_out_r[6];
                                shift_out_r <= {shift_out_r[6:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        miso_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Register file: SPI commit takes priority over a local write to the same address.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            if (commit_s) begin
                regs_r[addr_r] <= spi_wval_s;
            end
            if (loc_we && !(commit_s && (loc_addr == addr_r))) begin
                regs_r[loc_addr] <= loc_wval_s;
            end
        end
    end

`ifdef SPI_RESP_IRQ_EN
    logic irq_r;

    // Interrupt: any pending HIRQ bit that is also enabled in register 26.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(regs_r[HIRQ_ADDR] & regs_r[HIEN_ADDR]);
        end
    end

    assign irq = irq_r;
`else
    logic [7:0] hien_unused_s;
    assign hien_unused_s = regs_r[HIEN_ADDR] & regs_r[HIRQ_ADDR] & 8'h00;
    assign irq = |hien_unused_s;
`endif

    assign spi.spi_MISO = miso_r;
    assign loc_rdata    = regs_r[loc_addr];
    assign wr_strobe    = wr_strobe_r;
    assign wr_addr      = wr_addr_r;
    assign wr_data      = wr_data_r;
    assign busy         = busy_r;
endmodule
